// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants for seven-segment display blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational hex nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module      : seg_scan_driver
// Description : 8-digit multiplexed seven-segment scanner with frame-aligned
//               value update, anti-ghost blanking and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inVal,
    input  logic                  loadVal,
    input  logic [NUM_DIGITS-1:0] digEn,
    input  logic [NUM_DIGITS-1:0] dpIn,
    output logic                  busy,
    output logic [2:0]            count,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0]         r_prescaler;
    logic [2:0]            r_count;
    logic [31:0]           r_pending;
    logic [31:0]           r_active;
    logic                  r_busy;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic                  w_tick;
    logic                  w_frameEnd;
    logic [3:0]            w_nibble;
    logic [6:0]            w_segDec;
    logic [31:0]           w_upper;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_anOn;

    assign w_tick     = (r_prescaler == PW'(REFRESH_DIV - 1));
    assign w_frameEnd = w_tick && (r_count == 3'(NUM_DIGITS - 1));

    assign w_nibble = r_active[{r_count, 2'b00} +: 4];
    assign w_upper  = r_active >> {r_count, 2'b00};
    assign w_anOn   = ~(8'b1 << r_count);

    // A digit is suppressed when disabled, or when it and every higher digit are zero.
    assign w_blank = !digEn[r_count] ||
                     (BLANK_LZ && (r_count != 3'd0) && (w_upper == 32'd0));

    hex_to_seg u_hexToSeg (
        .nibble  (w_nibble),
        .pattern (w_segDec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler <= '0;
            r_count     <= 3'd0;
            r_pending   <= 32'd0;
            r_active    <= 32'd0;
            r_busy      <= 1'b0;
            r_an        <= AN_OFF;
            r_seg       <= SEG_OFF;
            r_dp        <= 1'b1;
        end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;

            if (w_tick) begin
                r_count <= r_count + 3'd1;
            end

            if (w_frameEnd && r_busy) begin
                r_active <= r_pending;
                r_busy   <= 1'b0;
            end

            // A load on the frame boundary wins over the busy clear above.
            if (loadVal) begin
                r_pending <= inVal;
                r_busy    <= 1'b1;
            end

            if (w_blank) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= w_tick ? AN_OFF : w_anOn;
                r_seg <= w_segDec;
                r_dp  <= ~dpIn[r_count];
            end
        end
    end

    assign busy  = r_busy;
    assign count = r_count;
    assign an    = r_an;
    assign seg   = r_seg;
    assign dp    = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Scoreboard bench for seg_scan_driver with REFRESH_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] inVal;
    logic        loadVal;
    logic [7:0]  digEn;
    logic [7:0]  dpIn;

    logic        busy,  busyL;
    logic [2:0]  count, countL;
    logic [7:0]  an,    anL;
    logic [6:0]  seg,   segL;
    logic        dp,    dpL;

    int errors = 0;
    int checks = 0;

    logic [15:0] sbQ[$];

    seg_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut (
        .clk(clk), .rst(rst), .inVal(inVal), .loadVal(loadVal),
        .digEn(digEn), .dpIn(dpIn), .busy(busy), .count(count),
        .an(an), .seg(seg), .dp(dp)
    );

    seg_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dutLz (
        .clk(clk), .rst(rst), .inVal(inVal), .loadVal(loadVal),
        .digEn(digEn), .dpIn(dpIn), .busy(busyL), .count(countL),
        .an(anL), .seg(segL), .dp(dpL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] expSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected {an, seg, dp} while digit k is lit.
    function automatic logic [15:0] expSlot(input logic [31:0] v, input logic [7:0] en,
                                            input logic [7:0] dpv, input bit lz, input int k);
        logic [31:0] upper;
        logic [7:0]  anv;
        upper = v >> (4 * k);
        if (!en[k] || (lz && k > 0 && upper == 32'd0))
            return {8'hFF, 7'h7F, 1'b1};
        anv = 8'hFF;
        anv[k] = 1'b0;
        return {anv, expSeg(upper[3:0]), ~dpv[k]};
    endfunction

    task automatic pushFrame(input logic [31:0] v, input bit lz);
        for (int k = 0; k < 8; k++) sbQ.push_back(expSlot(v, digEn, dpIn, lz, k));
    endtask

    task automatic loadPulse(input logic [31:0] v);
        inVal   = v;
        loadVal = 1'b1;
        @(negedge clk);
        loadVal = 1'b0;
    endtask

    // Returns at the first sample of a new frame (anti-ghost cycle of digit 0).
    task automatic waitFrameStart();
        logic [2:0] prev;
        bit         found;
        prev  = count;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (prev == 3'd7 && count == 3'd0) found = 1'b1;
            prev = count;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL frame_start: timeout, count=%0d required wrap 7->0", count);
        end
    endtask

    task automatic waitCount(input logic [2:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (count == target) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wait_count: timeout, count=%0d required %0d", count, target);
        end
    endtask

    // Entered on the anti-ghost sample of digit 0; leaves on that of the next frame.
    task automatic walkFrame(input bit sel, input string name);
        logic [15:0] exp, got;
        logic [7:0]  anNow;
        for (int k = 0; k < 8; k++) begin
            anNow = sel ? anL : an;
            checks++;
            if (anNow !== 8'hFF) begin
                errors++;
                $display("FAIL %s ghost d%0d: an=%h required ff", name, k, anNow);
            end
            @(negedge clk);
            got = sel ? {anL, segL, dpL} : {an, seg, dp};
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL %s d%0d: scoreboard empty, got %h", name, k, got);
                exp = 16'hxxxx;
            end else begin
                exp = sbQ.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s d%0d: an/seg/dp=%h/%h/%b required %h/%h/%b",
                             name, k, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
                end
            end
            checks++;
            if ((sel ? countL : count) !== 3'(k)) begin
                errors++;
                $display("FAIL %s count d%0d: count=%0d required %0d", name, k,
                         sel ? countL : count, k);
            end
            @(negedge clk);
            @(negedge clk);
            anNow = sel ? anL : an;
            checks++;
            if (anNow !== exp[15:8]) begin
                errors++;
                $display("FAIL %s hold d%0d: an=%h required %h", name, k, anNow, exp[15:8]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; loadVal = 1'b0; inVal = 32'd0; digEn = 8'hFF; dpIn = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({count, an, seg, dp, busy} !== {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: count/an/seg/dp/busy=%0d/%h/%h/%b/%b required 0/ff/7f/1/0",
                     count, an, seg, dp, busy);
        end
        checks++;
        if ({anL, segL, busyL} !== {8'hFF, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_lz: an/seg/busy=%h/%h/%b required ff/7f/0", anL, segL, busyL);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {8'hFE, 7'h40, 1'b1}) begin
            errors++;
            $display("FAIL first_lit: an/seg/dp=%h/%h/%b required fe/40/1", an, seg, dp);
        end
        checks++;
        if ({anL, segL} !== {8'hFE, 7'h40}) begin
            errors++;
            $display("FAIL first_lit_lz: an/seg=%h/%h required fe/40", anL, segL);
        end
    endtask

    task automatic test_load();
        loadPulse(32'h76543210);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy: busy=%b required 1", busy);
        end
        pushFrame(32'h76543210, 1'b0);
        waitFrameStart();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load_busy_clear: busy=%b required 0", busy);
        end
        walkFrame(1'b0, "load");
    endtask

    task automatic test_free_run();
        pushFrame(32'h76543210, 1'b0);
        walkFrame(1'b0, "free_run");
    endtask

    task automatic test_back_to_back();
        loadPulse(32'h11111111);
        @(negedge clk);
        loadPulse(32'h2468ACE0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: busy=%b required 1", busy);
        end
        pushFrame(32'h2468ACE0, 1'b0);
        waitFrameStart();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_clear: busy=%b required 0", busy);
        end
        walkFrame(1'b0, "b2b");

        // Second load lands on the frame_end cycle itself.
        loadPulse(32'h13579BDF);
        waitCount(3'd7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        loadPulse(32'hCAFE0123);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL coincide_busy: busy=%b required 1", busy);
        end
        pushFrame(32'h13579BDF, 1'b0);
        walkFrame(1'b0, "coincide_old");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL coincide_busy_clear: busy=%b required 0", busy);
        end
        pushFrame(32'hCAFE0123, 1'b0);
        walkFrame(1'b0, "coincide_new");
    endtask

    task automatic test_enable_dp();
        digEn = 8'h0F;
        dpIn  = 8'h02;
        loadPulse(32'hFEDCBA98);
        pushFrame(32'hFEDCBA98, 1'b0);
        waitFrameStart();
        walkFrame(1'b0, "en_dp");
        digEn = 8'hFF;
        dpIn  = 8'h00;
    endtask

    task automatic test_blank_lz();
        loadPulse(32'h00000A05);
        pushFrame(32'h00000A05, 1'b1);
        waitFrameStart();
        walkFrame(1'b1, "blank_lz");
        loadPulse(32'h00000000);
        pushFrame(32'h00000000, 1'b1);
        waitFrameStart();
        walkFrame(1'b1, "blank_lz_zero");
    endtask

    task automatic test_mid_reset();
        loadPulse(32'h89ABCDEF);
        waitCount(3'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({count, an, seg, dp, busy} !== {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrst: count/an/seg/dp/busy=%0d/%h/%h/%b/%b required 0/ff/7f/1/0",
                     count, an, seg, dp, busy);
        end
        @(negedge clk);
        checks++;
        if ({an, seg} !== {8'hFE, 7'h40}) begin
            errors++;
            $display("FAIL midrst_restart: an/seg=%h/%h required fe/40", an, seg);
        end
        pushFrame(32'h00000000, 1'b0);
        waitFrameStart();
        walkFrame(1'b0, "midrst_frame");
    endtask

    initial begin
        test_reset();
        test_load();
        test_free_run();
        test_back_to_back();
        test_enable_dp();
        test_blank_lz();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
